// File: rtl/bias_relu.sv
// ----------------------------------------------------------------------------
// bias_relu
//
// Adds a per-column FP32 bias to every element of a ROWS x COLS FP32 matrix and
// applies ReLU. One element is processed per clock, in row-major order,
// through a single shared combinational FP32 adder.
//
// Optional feature (compile-time macro):
//   BIAS_RELU_LEAKY_EN - leaky ReLU. Negative sums are scaled by
//                        2^-LEAK_SHIFT instead of being clamped to zero.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset (0 = reset)
//   start     in   one-cycle request; latches matrix_in and bias_in
//   matrix_in in   [ROWS][COLS][31:0] FP32 input matrix
//   bias_in   in   [COLS][31:0] FP32 bias, one per column
//   busy      out  high while elements are being processed
//   done      out  high while result is valid, held until the next accepted start
//   result    out  [ROWS][COLS][31:0] FP32 activated matrix
// ----------------------------------------------------------------------------
module bias_relu #(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [ROWS-1:0][COLS-1:0][31:0]   matrix_in,
    input  logic [COLS-1:0][31:0]             bias_in,
    output logic                              busy,
    output logic                              done,
    output logic [ROWS-1:0][COLS-1:0][31:0]   result
);

    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // FP32 add, round-to-nearest-even, subnormals flushed to zero.
    // The smaller-magnitude operand is aligned to the larger one with three
    // extra bits (guard, round, sticky), so the sign of a non-zero result is
    // always the sign of the larger operand.
    // ------------------------------------------------------------------------
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic              swap, sx, sub, found, rnd;
        logic [7:0]        ex, ey, d;
        logic [22:0]       fx, fy;
        logic [26:0]       xs, ys, al, mask, n;
        logic [27:0]       sum;
        logic [4:0]        lz;
        logic signed [9:0] e;
        logic [24:0]       mant;
        logic [31:0]       res;

        a_nan  = (&a[30:23]) && (|a[22:0]);
        b_nan  = (&b[30:23]) && (|b[22:0]);
        a_inf  = (&a[30:23]) && !(|a[22:0]);
        b_inf  = (&b[30:23]) && !(|b[22:0]);
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);

        // Larger magnitude becomes x; {exp,frac} orders like the magnitude.
        swap = (b[30:0] > a[30:0]);
        sx   = swap ? b[31]    : a[31];
        ex   = swap ? b[30:23] : a[30:23];
        fx   = swap ? b[22:0]  : a[22:0];
        ey   = swap ? a[30:23] : b[30:23];
        fy   = swap ? a[22:0]  : b[22:0];
        sub  = a[31] ^ b[31];
        d    = ex - ey;

        xs = {1'b1, fx, 3'b000};
        ys = {1'b1, fy, 3'b000};
        if (d > 8'd26) begin
            al = 27'd1;
        end else begin
            mask = (27'd1 << d) - 27'd1;
            al   = (ys >> d) | {26'd0, |(ys & mask)};
        end

        sum = sub ? ({1'b0, xs} - {1'b0, al}) : ({1'b0, xs} + {1'b0, al});
        e   = $signed({2'b00, ex});

        lz    = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && sum[i]) begin
                lz    = 5'(26 - i);
                found = 1'b1;
            end
        end

        if (sum[27]) begin
            n = {sum[27:2], sum[1] | sum[0]};
            e = e + 10'sd1;
        end else begin
            n = sum[26:0] << lz;
            e = e - $signed({5'd0, lz});
        end

        rnd  = n[2] & (n[3] | n[1] | n[0]);
        mant = {1'b0, n[26:3]} + {24'd0, rnd};
        if (mant[24]) begin
            mant = mant >> 1;
            e    = e + 10'sd1;
        end

        if (a_nan || b_nan || (a_inf && b_inf && sub)) begin
            res = QNAN;
        end else if (a_inf) begin
            res = {a[31], 8'hFF, 23'd0};
        end else if (b_inf) begin
            res = {b[31], 8'hFF, 23'd0};
        end else if (a_zero && b_zero) begin
            res = 32'd0;
        end else if (a_zero) begin
            res = b;
        end else if (b_zero) begin
            res = a;
        end else if (sum == 28'd0) begin
            res = 32'd0;
        end else if (e >= 10'sd255) begin
            res = {sx, 8'hFF, 23'd0};
        end else if (e <= 10'sd0) begin
            res = 32'd0;
        end else begin
            res = {sx, e[7:0], mant[22:0]};
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Activation: NaN canonicalised, negatives clamped (or leaky-scaled).
    // ------------------------------------------------------------------------
    function automatic logic [31:0] activate(input logic [31:0] s);
        logic [31:0] res;
        if ((&s[30:23]) && (|s[22:0])) begin
            res = QNAN;
        end else if (!s[31]) begin
            res = s;
        end else begin
`ifdef BIAS_RELU_LEAKY_EN
            if (&s[30:23]) begin
                res = NEG_INF;
            end else if (s[30:23] == 8'd0) begin
                res = 32'd0;
            end else if (s[30:23] <= 8'(LEAK_SHIFT)) begin
                res = 32'h8000_0000;
            end else begin
                res = {1'b1, s[30:23] - 8'(LEAK_SHIFT), s[22:0]};
            end
`else
            res = 32'd0;
`endif
        end
        return res;
    endfunction

    state_t                            state_q, state_d;
    logic [ROWS-1:0][COLS-1:0][31:0]   mat_q, result_q;
    logic [COLS-1:0][31:0]             bias_q;
    logic [RW-1:0]                     r_q;
    logic [CW-1:0]                     c_q;
    logic                              accept, last_elem;
    logic [31:0]                       elem_out;

    assign accept    = start && (state_q != RUN);
    assign last_elem = (r_q == RW'(ROWS - 1)) && (c_q == CW'(COLS - 1));
    assign elem_out  = activate(fp_add(mat_q[r_q][c_q], bias_q[c_q]));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: next_state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)     state_d = RUN;
            RUN:     if (last_elem) state_d = DONE;
            DONE:    if (start)     state_d = RUN;
            default:                state_d = IDLE;
        endcase
    end

    // NOTE: the result array is built from flops, not RAM, so it can and must
    // be cleared by reset along with the operand copies.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mat_q    <= '0;
            bias_q   <= '0;
            r_q      <= '0;
            c_q      <= '0;
            result_q <= '0;
        end else if (accept) begin
            mat_q  <= matrix_in;
            bias_q <= bias_in;
            r_q    <= '0;
            c_q    <= '0;
        end else if (state_q == RUN) begin
            result_q[r_q][c_q] <= elem_out;
            if (c_q == CW'(COLS - 1)) begin
                c_q <= '0;
                r_q <= last_elem ? '0 : r_q + RW'(1);
            end else begin
                c_q <= c_q + CW'(1);
            end
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_bias_relu.sv
// ----------------------------------------------------------------------------
// tb_bias_relu
//
// Directed bench for bias_relu: a 4x4 instance for the main sequence and a
// 2x3 instance for the non-square case. Expected results are queued when a
// start is issued and popped when done rises.
// ----------------------------------------------------------------------------
module tb_bias_relu;

    logic                     clk;
    logic                     rst;
    logic                     start4, start23;
    logic [3:0][3:0][31:0]    m4, res4;
    logic [3:0][31:0]         b4;
    logic [1:0][2:0][31:0]    m23, res23;
    logic [2:0][31:0]         b23;
    logic                     busy4, done4, busy23, done23;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    logic [31:0] exp_q[$];

    bias_relu #(.ROWS(4), .COLS(4), .LEAK_SHIFT(3)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .start     (start4),
        .matrix_in (m4),
        .bias_in   (b4),
        .busy      (busy4),
        .done      (done4),
        .result    (res4)
    );

    bias_relu #(.ROWS(2), .COLS(3), .LEAK_SHIFT(3)) dut23 (
        .clk       (clk),
        .rst       (rst),
        .start     (start23),
        .matrix_in (m23),
        .bias_in   (b23),
        .busy      (busy23),
        .done      (done23),
        .result    (res23)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_busy(input bit sel);
        return sel ? busy23 : busy4;
    endfunction

    function automatic logic cur_done(input bit sel);
        return sel ? done23 : done4;
    endfunction

    function automatic int nonzero4();
        int n = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (res4[r][c] !== 32'd0) n++;
        return n;
    endfunction

    // Returns at the falling edge following the accepting rising edge.
    task automatic pulse_start(input bit sel, input string tag);
        @(negedge clk);
        if (sel) start23 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        start4  = 1'b0;
        start23 = 1'b0;
        check({tag, "_done_low"}, {31'd0, cur_done(sel)}, 32'd0);
        check({tag, "_busy_high"}, {31'd0, cur_busy(sel)}, 32'd1);
    endtask

    // Counts cycles from the accepting edge until done; optionally re-pulses
    // start (with scrambled inputs) at cycle restart_at to show it is ignored.
    task automatic wait_done(input bit sel, input int n, input int restart_at, input string tag);
        int cycles   = 0;
        int busy_cnt = 0;
        while (!cur_done(sel) && cycles < 200) begin
            if (cur_busy(sel)) busy_cnt++;
            if (cycles == restart_at) begin
                start4 = 1'b1;
                m4     = {16{32'h4120_0000}};
                b4     = {4{32'hC2C8_0000}};
            end else begin
                start4 = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        start4 = 1'b0;
        check({tag, "_latency"}, 32'(cycles), 32'(n));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(n));
        check({tag, "_busy_at_done"}, {31'd0, cur_busy(sel)}, 32'd0);
    endtask

    task automatic compare_result(input bit sel, input string tag);
        int rows = sel ? 2 : 4;
        int cols = sel ? 3 : 4;
        logic [31:0] want, got;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                if (exp_q.size() == 0) begin
                    want = 32'hDEAD_BEEF;
                end else begin
                    want = exp_q.pop_front();
                end
                got = sel ? res23[r][c] : res4[r][c];
                check($sformatf("%s_r%0dc%0d", tag, r, c), got, want);
            end
        end
    endtask

    task automatic load_identity(input logic [31:0] bias, input logic [31:0] diag,
                                 input logic [31:0] off);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                m4[r][c] = (r == c) ? 32'h3F80_0000 : 32'd0;
                exp_q.push_back((r == c) ? diag : off);
            end
            b4[r] = bias;
        end
    endtask

    logic [31:0] rt_a   [4] = '{32'h3F80_0001, 32'h7F7F_FFFF, 32'h7F80_0000, 32'h0040_0000};
    logic [31:0] rt_b   [4] = '{32'h3380_0000, 32'h7F7F_FFFF, 32'hFF80_0000, 32'h0000_0000};
    logic [31:0] rt_exp [4] = '{32'h3F80_0002, 32'h7F80_0000, 32'h7FC0_0000, 32'h0000_0000};

`ifdef BIAS_RELU_LEAKY_EN
    localparam logic [31:0] NEG_HALF_OUT = 32'hBD80_0000;
    localparam logic [31:0] NEG_ONE_OUT  = 32'hBE00_0000;
`else
    localparam logic [31:0] NEG_HALF_OUT = 32'h0000_0000;
    localparam logic [31:0] NEG_ONE_OUT  = 32'h0000_0000;
`endif

    initial begin
        rst     = 1'b0;
        start4  = 1'b0;
        start23 = 1'b0;
        m4      = '0;
        b4      = '0;
        m23     = '0;
        b23     = '0;

        // Reset state.
        #3;
        check("reset_busy", {31'd0, busy4}, 32'd0);
        check("reset_done", {31'd0, done4}, 32'd0);
        check("reset_result_nonzero", 32'(nonzero4()), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Identity plus zero bias.
        load_identity(32'd0, 32'h3F80_0000, 32'd0);
        pulse_start(0, "ident");
        wait_done(0, 16, -1, "ident");
        compare_result(0, "ident");

        // Identity plus -0.5 bias, start re-pulsed mid-run and ignored.
        load_identity(32'hBF00_0000, 32'h3F00_0000, NEG_HALF_OUT);
        pulse_start(0, "negbias");
        wait_done(0, 16, 5, "negbias");
        compare_result(0, "negbias");

        // Rounding and special values in column 0; each restart comes from DONE.
        for (int t = 0; t < 4; t++) begin
            m4 = '0;
            b4 = '0;
            for (int r = 0; r < 4; r++) m4[r][0] = rt_a[t];
            b4[0] = rt_b[t];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    exp_q.push_back((c == 0) ? rt_exp[t] : 32'd0);
            pulse_start(0, $sformatf("round%0d", t));
            wait_done(0, 16, -1, $sformatf("round%0d", t));
            compare_result(0, $sformatf("round%0d", t));
        end

        // Asynchronous reset mid-run, then a clean restart.
        load_identity(32'd0, 32'h3F80_0000, 32'd0);
        pulse_start(0, "abort");
        repeat (8) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy4}, 32'd0);
        check("abort_done", {31'd0, done4}, 32'd0);
        check("abort_result_nonzero", 32'(nonzero4()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        load_identity(32'hBF00_0000, 32'h3F00_0000, NEG_HALF_OUT);
        pulse_start(0, "after_abort");
        wait_done(0, 16, -1, "after_abort");
        compare_result(0, "after_abort");

        // 2x3 instance with distinct column biases.
        m23 = {6{32'h3F80_0000}};
        b23[0] = 32'h3F80_0000;
        b23[1] = 32'hC000_0000;
        b23[2] = 32'h3F00_0000;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(32'h4000_0000);
            exp_q.push_back(NEG_ONE_OUT);
            exp_q.push_back(32'h3FC0_0000);
        end
        pulse_start(1, "m2x3");
        wait_done(1, 6, -1, "m2x3");
        compare_result(1, "m2x3");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
